// File: rtl/pico_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pico_spi_pkg
// Description : Shared types and constants for the pico SPI-flash fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pico_spi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        RESP = 3'd4,
        GAP  = 3'd5
    } state_e;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         CMD_BITS     = 8;
    localparam int         ADDR_BITS    = 24;
    localparam int         DATA_BITS    = 32;

    // Flash bytes arrive b0..b3; the core expects a little-endian word.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pico_spi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : pico_spi_sck_gen
// Description : SCK divider producing the SPI clock level plus rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_spi_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              C_DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_DW-1:0] C_DIV_LAST = C_DW'(CLK_DIV - 1);

    logic [C_DW-1:0] div_q, div_d;
    logic            sck_q, sck_d;
    logic            w_tick;

    assign w_tick = (div_q == C_DIV_LAST);

    // Strobes flag the upcoming edge on which sck will toggle.
    assign rise_o = !clr_i && w_tick && !sck_q;
    assign fall_o = !clr_i && w_tick &&  sck_q;
    assign sck_o  = sck_q;

    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        if (clr_i) begin
            div_d = '0;
            sck_d = 1'b0;
        end else if (w_tick) begin
            div_d = '0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pico_spi_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pico_spi_fetch
// Description : SPI READ (0x03) fetch stage returning one 32-bit word per request.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_spi_fetch
    import pico_spi_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    input  logic              flush,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              busy
);

    localparam int                 C_GAP_W     = $clog2(2 * CLK_DIV) + 1;
    localparam logic [C_GAP_W-1:0] C_GAP_LAST  = C_GAP_W'(2 * CLK_DIV - 1);
    localparam logic [5:0]         C_CMD_LAST  = 6'(CMD_BITS - 1);
    localparam logic [5:0]         C_ADDR_LAST = 6'(CMD_BITS + ADDR_BITS - 1);
    localparam logic [5:0]         C_DATA_LAST = 6'(CMD_BITS + ADDR_BITS + DATA_BITS - 1);

    state_e               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [31:0]          shout_q, shout_d;
    logic [31:0]          shin_q, shin_d;
    logic                 last_q, last_d;
    logic                 cs_n_q, cs_n_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic [C_GAP_W-1:0]   gap_q, gap_d;

    logic [23:0] w_addr24;
    logic        w_active, w_sck_clr, w_sck, w_rise, w_fall, w_accept;

    if (ADDR_W >= 24) begin : g_addr_trunc
        assign w_addr24 = req_addr[23:0];
    end else begin : g_addr_ext
        assign w_addr24 = {{(24 - ADDR_W){1'b0}}, req_addr};
    end

    assign w_active  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    // Stop the divider right after the 64th falling edge so no extra SCK pulse appears.
    assign w_sck_clr = !w_active || last_q || flush;

    pico_spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_sck_clr),
        .sck_o  (w_sck),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    assign req_ready = (state_q == IDLE) && !flush && !rst;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shout_d     = shout_q;
        shin_d      = shin_q;
        last_d      = last_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        gap_d       = (gap_q < C_GAP_LAST) ? gap_q + 1'b1 : gap_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = CMD;
                    cs_n_d  = 1'b0;
                    shout_d = {SPI_CMD_READ, w_addr24};
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
            CMD, ADDR, DATA: begin
                if (flush) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                    shout_d = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    gap_d   = '0;
                end else if (last_q) begin
                    state_d     = RESP;
                    cs_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = byte_swap32(shin_q);
                    last_d      = 1'b0;
                    gap_d       = '0;
                end else begin
                    if (w_rise && (state_q == DATA)) begin
                        shin_d = {shin_q[30:0], spi_miso};
                    end
                    if (w_fall) begin
                        cnt_d   = cnt_q + 1'b1;
                        shout_d = {shout_q[30:0], 1'b0};
                        if (cnt_q == C_CMD_LAST)  state_d = ADDR;
                        if (cnt_q == C_ADDR_LAST) state_d = DATA;
                        if (cnt_q == C_DATA_LAST) last_d  = 1'b1;
                    end
                end
            end
            RESP: begin
                if (flush || rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (gap_q >= C_GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shout_q     <= '0;
            shin_q      <= '0;
            last_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shout_q     <= shout_d;
            shin_q      <= shin_d;
            last_q      <= last_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            gap_q       <= gap_d;
        end
    end

    assign spi_cs_n  = cs_n_q;
    assign spi_sck   = w_sck;
    assign spi_mosi  = shout_q[31];
    assign busy      = ~cs_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pico_spi_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pico_spi_fetch
// Description : Self-checking bench; instance 0 uses CLK_DIV=1, instance 1 CLK_DIV=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_spi_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [23:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        flush     [2];
    logic        cs_n      [2];
    logic        sck       [2];
    logic        mosi      [2];
    logic        busy      [2];
    logic [31:0] hdr       [2];
    int          gap_bad   [2];

    logic [7:0] mem [0:1023];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          d;
        logic [23:0] addr;
        int          hold;
        logic [31:0] exp_word;
        int          exp_lat;
    } vec_t;
    vec_t tbl [5];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic        miso = 1'b0;
        int          bitn = 0;
        int          k;
        logic [31:0] cap  = '0;
        logic [9:0]  idx;
        logic [7:0]  b;
        int          hi   = 0;
        int          gbad = 0;
        bit          seen = 1'b0;

        pico_spi_fetch #(.CLK_DIV(g + 1), .ADDR_W(24)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g]),
            .flush     (flush[g]),
            .spi_cs_n  (cs_n[g]),
            .spi_sck   (sck[g]),
            .spi_mosi  (mosi[g]),
            .spi_miso  (miso),
            .busy      (busy[g])
        );

        // Flash model: header captured on SCK rise, data shifted out after SCK fall.
        always @(posedge sck[g], posedge cs_n[g]) begin
            if (cs_n[g] === 1'b1) begin
                bitn = 0;
            end else begin
                if (bitn < 32) cap = {cap[30:0], mosi[g]};
                bitn++;
            end
        end

        always @(negedge sck[g]) begin
            if (cs_n[g] === 1'b0 && bitn >= 32 && bitn < 64) begin
                k    = bitn - 32;
                idx  = cap[9:0] + 10'(k / 8);
                b    = mem[idx];
                miso = b[3'(7 - (k % 8))];
            end
        end

        always @(posedge clk) begin
            if (cs_n[g] === 1'b1) begin
                hi++;
            end else if (hi > 0) begin
                if (seen && hi < 2 * (g + 1)) gbad++;
                seen = 1'b1;
                hi   = 0;
            end
        end

        assign hdr[g]     = cap;
        assign gap_bad[g] = gbad;
    end

    function automatic logic [31:0] ref_word(input logic [23:0] a);
        logic [9:0] p;
        p = a[9:0];
        return {mem[p + 10'd3], mem[p + 10'd2], mem[p + 10'd1], mem[p]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (req_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready[d]), 32'd1);
    endtask

    task automatic issue(input int d, input logic [23:0] a);
        wait_ready(d);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        chk("start_csn", 32'(cs_n[d]), 32'd0);
    endtask

    task automatic finish(input int d, input logic [23:0] a, input int hold,
                          input logic [31:0] exp_word, input int exp_lat);
        int n = 0;
        bit ok = 1'b1;
        while (rsp_valid[d] !== 1'b1 && n < exp_lat + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("mosi_hdr", hdr[d], {8'h03, a});
        chk("rsp_data", rsp_data[d], exp_word);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== exp_word ||
                    cs_n[d] !== 1'b1 || req_ready[d] !== 1'b0) ok = 1'b0;
            end
            chk("hold_stable", 32'(ok), 32'd1);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("consumed_valid", 32'(rsp_valid[d]), 32'd0);
        chk("gap_ready_low", 32'(req_ready[d]), 32'd0);
    endtask

    initial begin
        bit          seen;
        bit          ok;
        int          d;
        int          hold;
        logic [23:0] a;

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[10'h100] = 8'h13;
        mem[10'h101] = 8'h05;
        mem[10'h102] = 8'h10;
        mem[10'h103] = 8'h00;

        tbl[0] = '{d: 0, addr: 24'h000100, hold: 0,  exp_word: 32'h00100513,         exp_lat: 129};
        tbl[1] = '{d: 0, addr: 24'h000200, hold: 20, exp_word: ref_word(24'h000200), exp_lat: 129};
        tbl[2] = '{d: 1, addr: 24'h000000, hold: 0,  exp_word: ref_word(24'h000000), exp_lat: 257};
        tbl[3] = '{d: 1, addr: 24'h000004, hold: 0,  exp_word: ref_word(24'h000004), exp_lat: 257};
        tbl[4] = '{d: 0, addr: 24'hABCFFE, hold: 3,  exp_word: ref_word(24'hABCFFE), exp_lat: 129};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_addr[i] = '0;
            rsp_ready[i] = 1'b0; flush[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_csn",   32'(cs_n[i]),      32'd1);
            chk("rst_sck",   32'(sck[i]),       32'd0);
            chk("rst_mosi",  32'(mosi[i]),      32'd0);
            chk("rst_ready", 32'(req_ready[i]), 32'd0);
            chk("rst_valid", 32'(rsp_valid[i]), 32'd0);
            chk("rst_data",  rsp_data[i],       32'd0);
            chk("rst_busy",  32'(busy[i]),      32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            issue(tbl[i].d, tbl[i].addr);
            finish(tbl[i].d, tbl[i].addr, tbl[i].hold, tbl[i].exp_word, tbl[i].exp_lat);
        end

        // Flush during address bit 15 on the CLK_DIV=1 instance.
        issue(0, 24'h000300);
        repeat (30) @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b0;
        chk("flush_csn",  32'(cs_n[0]), 32'd1);
        chk("flush_sck",  32'(sck[0]),  32'd0);
        chk("flush_busy", 32'(busy[0]), 32'd0);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) seen = 1'b1;
        end
        chk("flush_no_rsp", 32'(seen), 32'd0);
        issue(0, 24'h000008);
        finish(0, 24'h000008, 0, ref_word(24'h000008), 129);

        // Reset during data bit 40 on the CLK_DIV=2 instance.
        issue(1, 24'h000040);
        repeat (160) @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_csn",   32'(cs_n[1]),      32'd1);
        chk("mrst_sck",   32'(sck[1]),       32'd0);
        chk("mrst_mosi",  32'(mosi[1]),      32'd0);
        chk("mrst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("mrst_data",  rsp_data[1],       32'd0);
        chk("mrst_ready", 32'(req_ready[1]), 32'd0);
        rst[1] = 1'b0;
        seen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen = 1'b1;
        end
        chk("mrst_no_rsp", 32'(seen), 32'd0);
        issue(1, 24'h000050);
        finish(1, 24'h000050, 1, ref_word(24'h000050), 257);

        // Flush coinciding with a request in IDLE must win.
        wait_ready(0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h000010;
        flush[0]     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        ok = 1'b1;
        repeat (6) begin
            if (cs_n[0] !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        chk("flush_idle_csn", 32'(ok), 32'd1);

        for (int i = 0; i < 12; i++) begin
            d    = int'($urandom_range(0, 1));
            a    = 24'($urandom);
            hold = int'($urandom_range(0, 4));
            issue(d, a);
            finish(d, a, hold, ref_word(a), 128 * (d + 1) + 1);
        end

        repeat (4) @(negedge clk);
        chk("gap_div1", 32'(gap_bad[0]), 32'd0);
        chk("gap_div2", 32'(gap_bad[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
